// File: rtl/vend_credit_if.sv
// Bundles the coin/purchase inputs and the vend, change and display outputs
// of the vending credit controller.
interface vend_credit_if;
    logic        coin_5;
    logic        coin_10;
    logic        coin_25;
    logic        coin_100;
    logic [1:0]  sel;
    logic        buy;
    logic        cancel;
    logic        vend;
    logic [1:0]  vend_item;
    logic [13:0] change;
    logic        change_vld;
    logic        coin_reject;
    logic [13:0] cnt1;
    logic [6:0]  cnt2;
    logic        valid;
    logic        dp_en;
    logic [1:0]  dp_sel;
    logic [1:0]  mod_sel;
    logic        sign;

    modport slave (
        input  coin_5, coin_10, coin_25, coin_100, sel, buy, cancel,
        output vend, vend_item, change, change_vld, coin_reject,
               cnt1, cnt2, valid, dp_en, dp_sel, mod_sel, sign
    );

    modport master (
        output coin_5, coin_10, coin_25, coin_100, sel, buy, cancel,
        input  vend, vend_item, change, change_vld, coin_reject,
               cnt1, cnt2, valid, dp_en, dp_sel, mod_sel, sign
    );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending transaction controller: accumulates coin credit, sells items at fixed
// prices, returns change and feeds the seven-segment driver a D.CC value.
module vend_credit_ctrl #(
    parameter int PRICE_0     = 125,
    parameter int PRICE_1     = 150,
    parameter int PRICE_2     = 75,
    parameter int MAX_CREDIT  = 995,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    vend_credit_if.slave vc_if
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CREDIT, S_SHOW_PRICE, S_VEND_HOLD, S_CHANGE_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] credit_q, credit_d;
    logic [13:0] change_q, change_d;
    logic [13:0] cnt1_q, cnt1_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        vend_q, vend_d;
    logic [1:0]  vend_item_q, vend_item_d;
    logic        change_vld_q, change_vld_d;
    logic        coin_reject_q, coin_reject_d;
    logic        valid_q, valid_d;

    // Sums kept at 15 bits so the ceiling comparison can never wrap.
    logic [14:0] coin_val, credit_sum, price_sel;
    logic        coin_any, coin_ok, hold_done, buy_ok;

    always_comb begin
        coin_val = (vc_if.coin_5   ? 15'd5   : 15'd0) +
                   (vc_if.coin_10  ? 15'd10  : 15'd0) +
                   (vc_if.coin_25  ? 15'd25  : 15'd0) +
                   (vc_if.coin_100 ? 15'd100 : 15'd0);
        credit_sum = {1'b0, credit_q} + coin_val;
        coin_any   = vc_if.coin_5 | vc_if.coin_10 | vc_if.coin_25 | vc_if.coin_100;
        coin_ok    = credit_sum <= 15'(MAX_CREDIT);
        hold_done  = hold_q == HW'(HOLD_CYCLES - 1);
        buy_ok     = vc_if.buy && (vc_if.sel != 2'd3);
        case (vc_if.sel)
            2'd0:    price_sel = 15'(PRICE_0);
            2'd1:    price_sel = 15'(PRICE_1);
            2'd2:    price_sel = 15'(PRICE_2);
            default: price_sel = 15'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        cnt1_d        = cnt1_q;
        hold_d        = '0;
        vend_d        = 1'b0;
        vend_item_d   = vend_item_q;
        change_vld_d  = 1'b0;
        coin_reject_d = 1'b0;
        valid_d       = valid_q;

        case (state_q)
            S_IDLE: begin
                if (coin_any) begin
                    if (coin_ok) begin
                        credit_d = credit_sum[13:0];
                        cnt1_d   = credit_sum[13:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (vc_if.cancel) begin
                    coin_reject_d = coin_any;
                    change_d      = credit_q;
                    change_vld_d  = 1'b1;
                    cnt1_d        = credit_q;
                    credit_d      = '0;
                    state_d       = S_CHANGE_HOLD;
                end else if (buy_ok) begin
                    coin_reject_d = coin_any;
                    if ({1'b0, credit_q} < price_sel) begin
                        cnt1_d  = price_sel[13:0];
                        state_d = S_SHOW_PRICE;
                    end else begin
                        vend_d      = 1'b1;
                        vend_item_d = vc_if.sel;
                        credit_d    = credit_q - price_sel[13:0];
                        cnt1_d      = credit_q - price_sel[13:0];
                        valid_d     = 1'b0;
                        state_d     = S_VEND_HOLD;
                    end
                end else if (coin_any) begin
                    if (coin_ok) begin
                        credit_d = credit_sum[13:0];
                        cnt1_d   = credit_sum[13:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_SHOW_PRICE: begin
                coin_reject_d = coin_any;
                if (hold_done) begin
                    cnt1_d  = credit_q;
                    state_d = S_CREDIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_VEND_HOLD: begin
                coin_reject_d = coin_any;
                if (hold_done) begin
                    valid_d = 1'b1;
                    if (credit_q != '0) begin
                        change_d     = credit_q;
                        change_vld_d = 1'b1;
                        cnt1_d       = credit_q;
                        credit_d     = '0;
                        state_d      = S_CHANGE_HOLD;
                    end else begin
                        cnt1_d  = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_CHANGE_HOLD: begin
                coin_reject_d = coin_any;
                if (hold_done) begin
                    cnt1_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            change_q      <= '0;
            cnt1_q        <= '0;
            hold_q        <= '0;
            vend_q        <= 1'b0;
            vend_item_q   <= 2'd0;
            change_vld_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            valid_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            cnt1_q        <= cnt1_d;
            hold_q        <= hold_d;
            vend_q        <= vend_d;
            vend_item_q   <= vend_item_d;
            change_vld_q  <= change_vld_d;
            coin_reject_q <= coin_reject_d;
            valid_q       <= valid_d;
        end
    end

    // Decimal point after the dollars digit, cents mode, never negative.
    assign vc_if.vend        = vend_q;
    assign vc_if.vend_item   = vend_item_q;
    assign vc_if.change      = change_q;
    assign vc_if.change_vld  = change_vld_q;
    assign vc_if.coin_reject = coin_reject_q;
    assign vc_if.cnt1        = cnt1_q;
    assign vc_if.cnt2        = 7'd0;
    assign vc_if.valid       = valid_q;
    assign vc_if.dp_en       = 1'b1;
    assign vc_if.dp_sel      = 2'd1;
    assign vc_if.mod_sel     = 2'd2;
    assign vc_if.sign        = 1'b0;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: a transaction-level model queues the
// expected display values and pulses; a negedge monitor pops and compares them.
module tb_vend_credit_ctrl;
    localparam int HOLD = 8;
    localparam int MAXC = 995;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_credit_if vif();

    vend_credit_ctrl #(
        .PRICE_0(125), .PRICE_1(150), .PRICE_2(75),
        .MAX_CREDIT(MAXC), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vc_if(vif.slave)
    );

    typedef struct { int cyc; int val; } ev_t;
    typedef struct { int cyc; int cnt1; bit vld; } disp_t;
    ev_t   vend_eq[$];
    ev_t   chg_eq[$];
    ev_t   rej_eq[$];
    disp_t disp_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a credit balance plus "what the panel is showing and for how long".
    int m_credit, m_change, m_shown, hold_left, hold_kind;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int price_of(input int s);
        case (s)
            0: return 125;
            1: return 150;
            2: return 75;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_credit = 0; m_change = 0; m_shown = 0; hold_left = 0; hold_kind = 0;
    endtask

    task automatic step(input bit c5, input bit c10, input bit c25, input bit c100,
                        input int s, input bit b, input bit c);
        int coin;
        int t;
        bit rej;
        disp_t d;
        vif.coin_5 = c5; vif.coin_10 = c10; vif.coin_25 = c25; vif.coin_100 = c100;
        vif.sel = 2'(s); vif.buy = b; vif.cancel = c;
        coin = 5 * c5 + 10 * c10 + 25 * c25 + 100 * c100;
        t = cyc + 1;
        rej = 0;
        if (hold_left > 0) begin
            rej = coin > 0;
            hold_left--;
            if (hold_left == 0) begin
                if (hold_kind == 2 && m_credit > 0) begin
                    m_change = m_credit;
                    chg_eq.push_back('{t, m_credit});
                    m_credit = 0;
                    hold_kind = 3;
                    hold_left = HOLD;
                end else begin
                    hold_kind = 0;
                end
            end
        end else if (m_credit == 0) begin
            if (coin > 0) begin
                if (coin <= MAXC) m_credit = coin;
                else rej = 1;
            end
        end else if (c) begin
            rej = coin > 0;
            m_change = m_credit;
            chg_eq.push_back('{t, m_credit});
            m_credit = 0;
            hold_kind = 3; hold_left = HOLD;
        end else if (b && s != 3) begin
            rej = coin > 0;
            if (m_credit < price_of(s)) begin
                m_shown = price_of(s);
                hold_kind = 1; hold_left = HOLD;
            end else begin
                vend_eq.push_back('{t, s});
                m_credit -= price_of(s);
                hold_kind = 2; hold_left = HOLD;
            end
        end else if (coin > 0) begin
            if (m_credit + coin <= MAXC) m_credit += coin;
            else rej = 1;
        end
        if (rej) rej_eq.push_back('{t, coin});
        d.cyc = t; d.vld = 1'b1; d.cnt1 = m_credit;
        if (hold_left > 0) begin
            case (hold_kind)
                1: d.cnt1 = m_shown;
                2: d.vld = 1'b0;
                3: d.cnt1 = m_change;
                default: ;
            endcase
        end
        disp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [12:0] st_exp = 13'b0000000_0_1_01_10;

    always @(negedge clk) begin
        disp_t d;
        ev_t e;
        if (rst_n) begin
            if (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
                d = disp_q.pop_front();
                check("valid", int'(vif.valid), int'(d.vld));
                if (d.vld) check("cnt1", int'(vif.cnt1), d.cnt1);
                check("static_disp", int'({vif.cnt2, vif.sign, vif.dp_en, vif.dp_sel, vif.mod_sel}),
                      int'(st_exp));
            end
            if (vif.vend) begin
                if (vend_eq.size() == 0) check("vend_unexpected", 1, 0);
                else begin
                    e = vend_eq.pop_front();
                    check("vend_cycle", cyc, e.cyc);
                    check("vend_item", int'(vif.vend_item), e.val);
                end
            end
            if (vif.change_vld) begin
                if (chg_eq.size() == 0) check("change_unexpected", 1, 0);
                else begin
                    e = chg_eq.pop_front();
                    check("change_cycle", cyc, e.cyc);
                    check("change_amt", int'(vif.change), e.val);
                end
            end
            if (vif.coin_reject) begin
                if (rej_eq.size() == 0) check("reject_unexpected", 1, 0);
                else begin
                    e = rej_eq.pop_front();
                    check("reject_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vend"}, int'(vif.vend), 0);
        check({tag, "_change_vld"}, int'(vif.change_vld), 0);
        check({tag, "_coin_reject"}, int'(vif.coin_reject), 0);
        check({tag, "_cnt1"}, int'(vif.cnt1), 0);
        check({tag, "_change"}, int'(vif.change), 0);
        check({tag, "_vend_item"}, int'(vif.vend_item), 0);
        check({tag, "_valid"}, int'(vif.valid), 1);
        check({tag, "_static"}, int'({vif.cnt2, vif.sign, vif.dp_en, vif.dp_sel, vif.mod_sel}),
              int'(st_exp));
    endtask

    initial begin
        vif.coin_5 = 0; vif.coin_10 = 0; vif.coin_25 = 0; vif.coin_100 = 0;
        vif.sel = 0; vif.buy = 0; vif.cancel = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Build 150, buy item 0: vend, dashes, change 25, then idle.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2 * HOLD + 4);

        // Credit 50, buy item 1: price shown, credit restored, then cancel.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        idle(HOLD + 2);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(HOLD + 2);

        // Credit ceiling: reach 990, dime refused, nickel reaches 995.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(HOLD + 2);

        // Simultaneous coins, then cancel+buy+coin in one cycle.
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 1);
        idle(HOLD + 2);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++)
            step($urandom % 6 == 0, $urandom % 6 == 0, $urandom % 5 == 0, $urandom % 9 == 0,
                 int'($urandom % 4), $urandom % 8 == 0, $urandom % 30 == 0);
        idle(2 * HOLD + 4);

        // Reset in the middle of a vend hold with change pending.
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 2, 1, 0);
        idle(3);
        disp_q.delete(); vend_eq.delete(); chg_eq.delete(); rej_eq.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midhold_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(2 * HOLD + 4);
        @(negedge clk);
        #1;

        check("vend_leftover", vend_eq.size(), 0);
        check("change_leftover", chg_eq.size(), 0);
        check("reject_leftover", rej_eq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Vending-machine transaction controller that sits directly upstream of the seven-segment display driver.
- Accumulates coin credit in cents and accepts item purchases against fixed prices.
- Issues vend and change outputs.
- Drives the display driver's cnt1/cnt2/valid/dp_en/dp_sel/mod_sel/sign inputs so the panel shows credit, price or change as D.CC.

Parameters:
PRICE_0, 125, price of item 0 in cents
PRICE_1, 150, price of item 1 in cents
PRICE_2, 75, price of item 2 in cents
MAX_CREDIT, 995, credit ceiling in cents; must be at most 9999
HOLD_CYCLES, 1000, clk cycles each message state is held

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
coin_5  in  1  nickel inserted, 1-cycle pulse, already debounced and synchronous
coin_10  in  1  dime inserted, 1-cycle pulse
coin_25  in  1  quarter inserted, 1-cycle pulse
coin_100  in  1  dollar inserted, 1-cycle pulse
sel  in  2  item select (0..2); 3 is invalid
buy  in  1  purchase request, 1-cycle pulse
cancel  in  1  refund request, 1-cycle pulse
vend  out  1  1-cycle dispense pulse
vend_item  out  2  item being dispensed, valid with vend
change  out  14  change amount in cents, valid with change_vld
change_vld  out  1  1-cycle change-return pulse
coin_reject  out  1  1-cycle pulse when a coin is refused
cnt1  out  14  display value in cents
cnt2  out  7  display secondary value, always 0
valid  out  1  display valid (0 shows dashes)
dp_en  out  1  decimal point enable
dp_sel  out  2  decimal point digit index
mod_sel  out  2  display mode
sign  out  1  display sign, always 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs registered. On reset, credit=0, state=IDLE, vend/change_vld/coin_reject=0, change=0, vend_item=0, cnt1=0, cnt2=0, valid=1, dp_en=1, dp_sel=1, mod_sel=2, sign=0.
- Reset mid-transaction discards credit and aborts any hold. No vend or change pulse is issued.
- Coin value: coin_val is the sum of all coin pulses asserted in a cycle (5/10/25/100). Simultaneous coins are summed.
- Coin acceptance: in IDLE/CREDIT, if credit+coin_val ≤ MAX_CREDIT, credit updates on the next edge. Otherwise credit is unchanged and coin_reject pulses the next cycle.
- Coins in hold states: coins arriving in any hold state are rejected (coin_reject pulse).
- States: IDLE, CREDIT, SHOW_PRICE, VEND_HOLD, CHANGE_HOLD.
- IDLE: credit=0; cnt1=0. Any accepted coin moves to CREDIT. buy and cancel are ignored.
- CREDIT: cnt1=credit.
  - buy with sel=3: ignored.
  - buy with credit < price(sel): go to SHOW_PRICE. cnt1=price; credit is kept.
  - buy with credit ≥ price(sel): vend=1 and vend_item=sel next cycle; credit ← credit−price; go to VEND_HOLD.
  - cancel: go to CHANGE_HOLD with change=credit. change_vld=1 next cycle; credit ← 0.
  - Priority when events coincide in one cycle: cancel > buy > coin. A coin arriving with buy or cancel is rejected.
- SHOW_PRICE: held HOLD_CYCLES cycles, then returns to CREDIT.
- VEND_HOLD: valid=0 (dashes) for HOLD_CYCLES.
  - If remaining credit > 0: go to CHANGE_HOLD. change=credit and change_vld pulses on entry; credit ← 0.
  - Otherwise: go to IDLE.
- CHANGE_HOLD: cnt1=change for HOLD_CYCLES, then IDLE.
- Hold counter: a hold counter counts 0..HOLD_CYCLES−1 and clears on every state entry. buy and cancel are ignored during holds.
- Latency: input pulse at edge N produces the state, credit, pulse outputs and cnt1 at edge N+1.
- Pulses: vend, change_vld and coin_reject are never high for more than 1 cycle.
- Width rule: internal sums are 15 bits, so an overflow check is never wrapped.

Test Plan:
1. Reset, then 25+25+100 pulses → cnt1 reaches 150; valid=1, dp_sel=1, mod_sel=2.
2. Credit 150, sel=0, buy → vend=1 and vend_item=0 one cycle later; valid=0 for HOLD_CYCLES; then change_vld with change=25; cnt1=25 for HOLD_CYCLES; then IDLE with cnt1=0.
3. Credit 50, sel=1, buy → cnt1=150 for HOLD_CYCLES; then cnt1=50 again; no vend.
4. Credit 990, coin_10 → coin_reject=1 and credit stays 990. Next, coin_5 → credit 995.
5. Same cycle: coin_25+coin_10 → credit+35. Same cycle: cancel+buy+coin_5 with credit 75 → change=75, no vend, coin_reject=1.
6. Credit 75, rst_n low mid-VEND_HOLD → all outputs at reset values immediately; no change_vld after release.
